life_gen_ctrl: RTL
==================

Name: life_gen_ctrl

Overview:
- Sequences one Game-of-Life generation update over the 1-bit-per-cell grid memory that the pixel generator displays.
- Walks every cell in raster order and issues nine reads per cell (the centre plus 8 neighbours, toroidal wrap) from the displayed bank.
- Applies rule B3/S23 and writes the next state to the hidden bank.
- Swaps the displayed bank only at a frame boundary so the video stream never tears.

Parameters:
- GRID_W, 640, cells per row.
- GRID_H, 480, rows.
- ADDR_W, $clog2(GRID_W*GRID_H), cell address width; address = y*GRID_W + x.

Ports:
- aclk  in  1  clock for all logic and the memory ports.
- aresetn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to compute one generation.
- sof  in  1  start-of-frame pulse from the pixel stream (first pixel accepted).
- mem_rd_en  out  1  read strobe; reads bank display_bank.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  1  cell state, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  out  1  write strobe; writes bank ~display_bank.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  1  next cell state.
- display_bank  out  1  bank the display (and this block's reads) uses.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse in the cycle display_bank toggles.
- gen_count  out  16  number of completed generations; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (async, aresetn=0):
  - State goes to IDLE; display_bank=0, gen_count=0.
  - busy, done, mem_rd_en and mem_wr_en go to 0; addresses and wr_data go to 0.
  - Memory contents are untouched.
  - Reset mid-generation abandons the update with no bank swap; the partially written hidden bank is don't-care.
- States: IDLE, FETCH, ACC, WRITE, SWAP_WAIT.
- IDLE: on start=1, set x=0, y=0, busy=1, go to FETCH. start in any other state is ignored; it is not queued.
- FETCH: lasts 9 cycles, k=0..8, with mem_rd_en=1 each cycle.
  - Read order: centre (x,y), then NW, N, NE, W, E, SW, S, SE.
  - Neighbour coordinates wrap: x-1 at x=0 gives GRID_W-1; x+1 at GRID_W-1 gives 0; y wraps the same way with GRID_H.
- Capture: mem_rd_data for read k is captured in cycle k+1.
  - Read 0 goes to the centre register.
  - Reads 1..8 accumulate into a 4-bit neighbour count (0..8), cleared at the start of each cell.
- ACC: 1 cycle with mem_rd_en=0; captures read 8.
- WRITE: 1 cycle with mem_wr_en=1, mem_wr_addr = address of (x,y).
  - mem_wr_data = (count==3) | (centre & count==2).
  - Then advance: x+1; at x=GRID_W-1 set x=0 and y+1.
  - Last cell (GRID_W-1, GRID_H-1) goes to SWAP_WAIT; otherwise go to FETCH.
- Throughput: exactly 11 cycles per cell, so 11*GRID_W*GRID_H cycles from the FETCH entry to the SWAP_WAIT entry.
- SWAP_WAIT: wait for sof=1. In that cycle (registered, effective on the next edge):
  - display_bank toggles, gen_count increments;
  - done=1 for one cycle, busy=0;
  - state returns to IDLE.
  - An sof in the same cycle as SWAP_WAIT entry is not used; only sof while in SWAP_WAIT counts.
- sof outside SWAP_WAIT has no effect.
- A start in the same cycle as done is ignored; start is accepted only in IDLE.
- mem_rd_en and mem_wr_en are never both high in the same cycle.

Test Plan:
- Reset values: GRID_W=8, GRID_H=6; assert aresetn=0 asynchronously mid-cycle -> display_bank=0, gen_count=0, busy=0, both mem enables 0 immediately, without waiting for a clock edge.
- Blinker: bank0 holds (3,2),(3,3),(3,4) live; start, then sof -> bank1 holds exactly (2,3),(3,3),(4,3); display_bank=1, gen_count=1; a second generation restores the vertical line in bank0.
- Wrap: corners (0,0),(7,0),(0,5),(7,5) live -> after one generation bank1 holds the same four cells (wrapped block, each with 3 neighbours); all other 44 cells are 0.
- Timing: start at cycle T -> first mem_rd_en at T+1 with addr 0; first mem_wr_en at T+11; SWAP_WAIT entered after 528 cycles; exactly 48 writes and 432 reads; no done until sof.
- Swap gating/ignore: sof pulses during FETCH -> no effect; start pulses while busy -> no second generation (gen_count +1 only); sof 20 cycles into SWAP_WAIT -> done exactly once, at that point.
- Reset mid-op: aresetn low after 200 cycles -> IDLE, display_bank stays 0, bank0 unchanged; a new start completes normally with correct results.

Source files
------------

// File: rtl/life_gen_ctrl_if.sv
// ---------------------------------------------------------------------------
// life_gen_ctrl_if
//   Bundles the control handshake, the grid-memory read/write ports and the
//   status outputs of the Game-of-Life generation sequencer.
//
//   master : the sequencer (drives memory strobes and status)
//   slave  : the surrounding system (start/sof source and grid memory)
//
//   start        single-cycle request to compute one generation
//   sof          start-of-frame pulse from the pixel stream
//   mem_rd_en    read strobe into bank display_bank
//   mem_rd_addr  read address, y*GRID_W + x
//   mem_rd_data  cell state, valid one cycle after mem_rd_en
//   mem_wr_en    write strobe into bank ~display_bank
//   mem_wr_addr  write address
//   mem_wr_data  next cell state
//   display_bank bank shown on screen and read by the sequencer
//   busy         high from accepted start until done
//   done         one-cycle pulse when display_bank toggles
//   gen_count    completed generations, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
interface life_gen_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              start;
    logic              sof;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              mem_wr_data;
    logic              display_bank;
    logic              busy;
    logic              done;
    logic [15:0]       gen_count;

    modport master (
        input  start, sof, mem_rd_data,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output display_bank, busy, done, gen_count
    );

    modport slave (
        output start, sof, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  display_bank, busy, done, gen_count
    );
endinterface

// File: rtl/life_gen_ctrl.sv
// ---------------------------------------------------------------------------
// life_gen_ctrl
//   Computes one Game-of-Life generation (rule B3/S23, toroidal grid) over a
//   double-buffered 1-bit-per-cell memory. Each cell costs 11 cycles:
//   9 reads (centre, NW, N, NE, W, E, SW, S, SE), one capture cycle for the
//   last read, and one write into the hidden bank. The displayed bank is
//   swapped only on a start-of-frame pulse so the video never tears.
//
//   aclk     clock for all logic and memory ports
//   aresetn  asynchronous active-low reset
//   bus      life_gen_ctrl_if.master (handshake, memory ports, status)
// ---------------------------------------------------------------------------
module life_gen_ctrl #(
    parameter int GRID_W = 640,
    parameter int GRID_H = 480,
    parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input logic              aclk,
    input logic              aresetn,
    life_gen_ctrl_if.master  bus
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACC,
        WRITE,
        SWAP_WAIT
    } state_t;

    state_t            state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [3:0]        k_q;
    logic              centre_q;
    logic [3:0]        count_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_data_q;
    logic              bank_q;
    logic [15:0]       gen_q;
    logic              busy_q;
    logic              done_q;

    logic [XW-1:0]     xm, xp, rdX;
    logic [YW-1:0]     ym, yp, rdY, yAdv;
    logic              lastCol, lastRow;
    logic [3:0]        kNext;
    logic [3:0]        countFull;
    logic              nextLive;
    logic [ADDR_W-1:0] nextRdAddr;

    function automatic logic [ADDR_W-1:0] addrOf(input logic [XW-1:0] cx,
                                                 input logic [YW-1:0] cy);
        return ADDR_W'(int'(cy) * GRID_W + int'(cx));
    endfunction

    // Wrapped neighbour coordinates of the current cell. xp doubles as the
    // raster-advance x because it already wraps to 0 at the last column.
    always_comb begin
        lastCol = (x_q == XW'(GRID_W - 1));
        lastRow = (y_q == YW'(GRID_H - 1));
        xm      = (x_q == '0) ? XW'(GRID_W - 1) : x_q - 1'b1;
        xp      = lastCol ? '0 : x_q + 1'b1;
        ym      = (y_q == '0) ? YW'(GRID_H - 1) : y_q - 1'b1;
        yp      = lastRow ? '0 : y_q + 1'b1;
        yAdv    = lastCol ? yp : y_q;
    end

    // Address of the read that follows the one currently on the bus, in the
    // fixed order centre, NW, N, NE, W, E, SW, S, SE.
    always_comb begin
        kNext = k_q + 4'd1;
        rdX   = x_q;
        rdY   = y_q;
        case (kNext)
            4'd1: begin rdX = xm; rdY = ym; end
            4'd2: begin rdY = ym;           end
            4'd3: begin rdX = xp; rdY = ym; end
            4'd4: begin rdX = xm;           end
            4'd5: begin rdX = xp;           end
            4'd6: begin rdX = xm; rdY = yp; end
            4'd7: begin rdY = yp;           end
            4'd8: begin rdX = xp; rdY = yp; end
            default: ;
        endcase
        nextRdAddr = addrOf(rdX, rdY);
    end

    // Neighbour total including the read landing this cycle, and the B3/S23
    // decision made from it during ACC.
    always_comb begin
        countFull = count_q + {3'b000, bus.mem_rd_data};
        nextLive  = (countFull == 4'd3) | (centre_q & (countFull == 4'd2));
    end

    // Sequencer. All bus outputs are registered so that the strobe for a
    // state appears in the first cycle of that state. A start seen while
    // done is still high is dropped, so a start cannot ride on the done
    // cycle into a new generation.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            centre_q  <= 1'b0;
            count_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
            bank_q    <= 1'b0;
            gen_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !done_q) begin
                        x_q       <= '0;
                        y_q       <= '0;
                        k_q       <= '0;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    // Data on mem_rd_data belongs to read k-1.
                    if (k_q == 4'd1) begin
                        centre_q <= bus.mem_rd_data;
                    end else if (k_q > 4'd1) begin
                        count_q <= countFull;
                    end
                    if (k_q == 4'd8) begin
                        rd_en_q <= 1'b0;
                        state_q <= ACC;
                    end else begin
                        k_q       <= kNext;
                        rd_addr_q <= nextRdAddr;
                    end
                end
                ACC: begin
                    count_q   <= countFull;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addrOf(x_q, y_q);
                    wr_data_q <= nextLive;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    x_q     <= xp;
                    y_q     <= yAdv;
                    if (lastCol && lastRow) begin
                        state_q <= SWAP_WAIT;
                    end else begin
                        k_q       <= '0;
                        count_q   <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addrOf(xp, yAdv);
                        state_q   <= FETCH;
                    end
                end
                SWAP_WAIT: begin
                    if (bus.sof) begin
                        bank_q  <= ~bank_q;
                        gen_q   <= gen_q + 16'd1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en    = rd_en_q;
    assign bus.mem_rd_addr  = rd_addr_q;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_wr_addr  = wr_addr_q;
    assign bus.mem_wr_data  = wr_data_q;
    assign bus.display_bank = bank_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.gen_count    = gen_q;

endmodule
